// File: rtl/clock_pkg.sv
// Shared field layout, limits and stepping helpers for the 12-hour timekeeper.
package clock_pkg;

  localparam int HR_MSB = 11;
  localparam int HR_LSB = 8;
  localparam int TM_MSB = 7;
  localparam int TM_LSB = 4;
  localparam int MN_MSB = 3;
  localparam int MN_LSB = 0;

  localparam logic [3:0]  HR_MAX     = 4'd12;
  localparam logic [3:0]  HR_MIN     = 4'd1;
  localparam logic [3:0]  HR_PM_FLIP = 4'd11;
  localparam logic [3:0]  TM_MAX     = 4'd5;
  localparam logic [3:0]  MN_MAX     = 4'd9;
  localparam logic [5:0]  SEC_MAX    = 6'd59;
  localparam logic [11:0] RESET_WORD = 12'hC00;

  typedef struct packed {
    logic [3:0] hr;
    logic [3:0] tm;
    logic [3:0] mn;
  } hhmm_t;

  typedef struct packed {
    logic [3:0] tm;
    logic [3:0] mn;
    logic       carry;
  } min_step_t;

  // Out-of-range hours fold back to 1 so the field can never stick at 0 or 13..15.
  function automatic logic [3:0] next_hour(input logic [3:0] hr);
    return (hr >= HR_MAX) ? HR_MIN : hr + 4'd1;
  endfunction

  function automatic min_step_t next_minute(input logic [3:0] tm, input logic [3:0] mn);
    min_step_t r;
    r.tm    = tm;
    r.mn    = mn + 4'd1;
    r.carry = 1'b0;
    if (mn >= MN_MAX) begin
      r.mn = 4'd0;
      if (tm >= TM_MAX) begin
        r.tm    = 4'd0;
        r.carry = 1'b1;
      end else begin
        r.tm = tm + 4'd1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchronizer plus delay flop; emits either the synchronized level
// or a one-cycle rising-edge pulse.
module btn_sync_edge #(
  parameter bit rise_out = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic out
);

  logic       s1, s2, s_d, armed;
  logic [1:0] fill;
  logic       rise;

  // NOTE: non-blocking assignments make each flop sample the previous stage's old value, forming a real shift chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      s_d   <= 1'b0;
      fill  <= 2'b00;
      armed <= 1'b0;
    end else begin
      s1    <= din;
      s2    <= s1;
      s_d   <= s2;
      fill  <= {fill[0], 1'b1};
      // Edges only count once a post-reset low has been seen, so a button held through reset never steps.
      armed <= armed | (fill[1] & ~s2);
    end
  end

  assign rise = s2 & ~s_d & armed;
  assign out  = rise_out ? rise : s2;

endmodule

// File: rtl/clock_timekeeper.sv
// 12-hour wall clock with AM/PM, set mode via hour/minute buttons, and a
// 1 Hz decimal-point blink for the 7-segment display controller.
module clock_timekeeper
  import clock_pkg::*;
#(
  parameter int sys_freq = 100000000,
  parameter int sec_div  = sys_freq
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        set_mode,
  input  logic        btn_hr,
  input  logic        btn_min,
  output logic [11:0] time_bus,
  output logic        dp_out,
  output logic        pm
);

  localparam int PW = (sec_div > 1) ? $clog2(sec_div) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(sec_div - 1);
  localparam logic [PW-1:0] PRESC_HALF = PW'(sec_div / 2);

  logic          set_mode_s, hr_pulse, min_pulse;
  logic [PW-1:0] presc;
  logic [5:0]    sec;
  hhmm_t         cur;
  min_step_t     ms;
  logic          tick;

  btn_sync_edge #(.rise_out(1'b0)) u_set_sync (.clk(clk), .rst(rst), .din(set_mode), .out(set_mode_s));
  btn_sync_edge #(.rise_out(1'b1)) u_hr_sync  (.clk(clk), .rst(rst), .din(btn_hr),   .out(hr_pulse));
  btn_sync_edge #(.rise_out(1'b1)) u_min_sync (.clk(clk), .rst(rst), .din(btn_min),  .out(min_pulse));

  // NOTE: the helper returns a fully assigned struct on every path, so this block cannot infer a latch.
  always_comb ms = next_minute(cur.tm, cur.mn);

  assign tick = (presc == PRESC_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      presc  <= '0;
      sec    <= '0;
      cur    <= RESET_WORD;
      pm     <= 1'b0;
      dp_out <= 1'b0;
    end else if (set_mode_s) begin
      // Time is frozen; a tick coinciding with entry is simply dropped.
      presc  <= '0;
      sec    <= '0;
      dp_out <= 1'b1;
      if (hr_pulse) begin
        cur.hr <= next_hour(cur.hr);
        if (cur.hr == HR_PM_FLIP) pm <= ~pm;
      end
      if (min_pulse) begin
        cur.tm <= ms.tm;
        cur.mn <= ms.mn;
      end
    end else begin
      dp_out <= (presc < PRESC_HALF);
      if (tick) begin
        presc <= '0;
        if (sec == SEC_MAX) begin
          sec    <= '0;
          cur.tm <= ms.tm;
          cur.mn <= ms.mn;
          if (ms.carry) begin
            cur.hr <= next_hour(cur.hr);
            if (cur.hr == HR_PM_FLIP) pm <= ~pm;
          end
        end else begin
          sec <= sec + 6'd1;
        end
      end else begin
        presc <= presc + PW'(1);
      end
    end
  end

  assign time_bus[HR_MSB:HR_LSB] = cur.hr;
  assign time_bus[TM_MSB:TM_LSB] = cur.tm;
  assign time_bus[MN_MSB:MN_LSB] = cur.mn;

endmodule

// File: tb/tb_clock_timekeeper.sv
// Scenario bench for clock_timekeeper with a small time model and an expectation queue.
module tb_clock_timekeeper;

  localparam int SEC_DIV = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        set_mode = 1'b0;
  logic        btn_hr = 1'b0;
  logic        btn_min = 1'b0;
  logic [11:0] time_bus;
  logic        dp_out;
  logic        pm;

  clock_timekeeper #(.sys_freq(100), .sec_div(SEC_DIV)) dut (
    .clk(clk), .rst(rst), .set_mode(set_mode), .btn_hr(btn_hr), .btn_min(btn_min),
    .time_bus(time_bus), .dp_out(dp_out), .pm(pm)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [11:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [3:0] m_hr, m_tm, m_mn;
  logic       m_pm;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input string name, input logic [11:0] v);
    exp_t e;
    e.name = name;
    e.val  = v;
    sb.push_back(e);
  endtask

  function automatic logic [11:0] m_word();
    return {m_hr, m_tm, m_mn};
  endfunction

  task automatic m_hour_step();
    if (m_hr == 4'd11) m_pm = ~m_pm;
    m_hr = (m_hr == 4'd12) ? 4'd1 : m_hr + 4'd1;
  endtask

  task automatic m_min_step();
    if (m_mn == 4'd9) begin
      m_mn = 4'd0;
      m_tm = (m_tm == 4'd5) ? 4'd0 : m_tm + 4'd1;
    end else begin
      m_mn = m_mn + 4'd1;
    end
  endtask

  task automatic m_run_minute();
    if (m_tm == 4'd5 && m_mn == 4'd9) begin
      m_tm = 4'd0;
      m_mn = 4'd0;
      m_hour_step();
    end else begin
      m_min_step();
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    m_hr = 4'd12; m_tm = 4'd0; m_mn = 4'd0; m_pm = 1'b0;
  endtask

  // One full press/release; the model only follows when the DUT should act on it.
  task automatic press(input bit h, input bit m, input bit applies);
    btn_hr = h; btn_min = m;
    step(3);
    btn_hr = 1'b0; btn_min = 1'b0;
    step(3);
    if (applies && h) m_hour_step();
    if (applies && m) m_min_step();
  endtask

  task automatic enter_set();
    set_mode = 1'b1;
    step(3);
  endtask

  task automatic set_to(input logic [3:0] hr, input logic [3:0] tm, input logic [3:0] mn);
    while (m_hr != hr) press(1'b1, 1'b0, 1'b1);
    while (m_tm != tm || m_mn != mn) press(1'b0, 1'b1, 1'b1);
  endtask

  task automatic test_reset();
    exp_t e;
    do_reset();
    push("rst_time", 12'hC00); push("rst_pm", 12'd0); push("rst_dp", 12'd0);
    e = sb.pop_front(); n_cmp++;
    if (time_bus !== e.val) begin n_bad++; $display("FAIL %s: got %h expected %h", e.name, time_bus, e.val); end
    e = sb.pop_front(); n_cmp++;
    if ({11'd0, pm} !== e.val) begin n_bad++; $display("FAIL %s: got %0d expected %0d", e.name, pm, e.val); end
    e = sb.pop_front(); n_cmp++;
    if ({11'd0, dp_out} !== e.val) begin n_bad++; $display("FAIL %s: got %0d expected %0d", e.name, dp_out, e.val); end
    push("sec1_time", 12'hC00); push("sec1_sec", 12'd1); push("sec1_presc", 12'd0);
    step(SEC_DIV);
    e = sb.pop_front(); n_cmp++;
    if (time_bus !== e.val) begin n_bad++; $display("FAIL %s: got %h expected %h", e.name, time_bus, e.val); end
    e = sb.pop_front(); n_cmp++;
    if (12'(dut.sec) !== e.val) begin n_bad++; $display("FAIL %s: got %0d expected %0d", e.name, dut.sec, e.val); end
    e = sb.pop_front(); n_cmp++;
    if (12'(dut.presc) !== e.val) begin n_bad++; $display("FAIL %s: got %0d expected %0d", e.name, dut.presc, e.val); end
  endtask

  // Set hh:mm, leave set mode and check the word just before and at the minute carry.
  task automatic run_minute_from(input string tag, input logic [3:0] hr);
    exp_t e;
    enter_set();
    set_to(hr, 4'd5, 4'd9);
    push({tag, "_preload"}, m_word());
    e = sb.pop_front(); n_cmp++;
    if (time_bus !== e.val) begin n_bad++; $display("FAIL %s: got %h expected %h", e.name, time_bus, e.val); end
    set_mode = 1'b0;
    push({tag, "_before"}, m_word());
    m_run_minute();
    push({tag, "_after"}, m_word());
    push({tag, "_pm"}, {11'd0, m_pm});
    step(2 + 60 * SEC_DIV - 1);
    e = sb.pop_front(); n_cmp++;
    if (time_bus !== e.val) begin n_bad++; $display("FAIL %s: got %h expected %h", e.name, time_bus, e.val); end
    step(1);
    e = sb.pop_front(); n_cmp++;
    if (time_bus !== e.val) begin n_bad++; $display("FAIL %s: got %h expected %h", e.name, time_bus, e.val); end
    e = sb.pop_front(); n_cmp++;
    if ({11'd0, pm} !== e.val) begin n_bad++; $display("FAIL %s: got %0d expected %0d", e.name, pm, e.val); end
  endtask

  task automatic test_run_carry();
    run_minute_from("b59", 4'd11);
    run_minute_from("c59", 4'd12);
  endtask

  task automatic test_min_hold();
    exp_t e;
    do_reset();
    enter_set();
    btn_min = 1'b1;
    push("hold_e1", 12'hC00); push("hold_e2", 12'hC00); push("hold_e3", 12'hC01);
    for (int i = 0; i < 3; i++) begin
      step(1);
      e = sb.pop_front(); n_cmp++;
      if (time_bus !== e.val) begin n_bad++; $display("FAIL %s: got %h expected %h", e.name, time_bus, e.val); end
    end
    m_min_step();
    push("hold_50", m_word());
    step(47);
    e = sb.pop_front(); n_cmp++;
    if (time_bus !== e.val) begin n_bad++; $display("FAIL %s: got %h expected %h", e.name, time_bus, e.val); end
    btn_min = 1'b0;
    step(3);
    for (int i = 0; i < 58; i++) press(1'b0, 1'b1, 1'b1);
    push("min_59", m_word());
    e = sb.pop_front(); n_cmp++;
    if (time_bus !== e.val) begin n_bad++; $display("FAIL %s: got %h expected %h", e.name, time_bus, e.val); end
    press(1'b0, 1'b1, 1'b1);
    push("min_wrap", m_word());
    e = sb.pop_front(); n_cmp++;
    if (time_bus !== e.val) begin n_bad++; $display("FAIL %s: got %h expected %h", e.name, time_bus, e.val); end
  endtask

  task automatic test_both_and_run_ignore();
    exp_t e;
    set_to(4'd11, 4'd5, 4'd9);
    push("both_pre", m_word());
    e = sb.pop_front(); n_cmp++;
    if (time_bus !== e.val) begin n_bad++; $display("FAIL %s: got %h expected %h", e.name, time_bus, e.val); end
    press(1'b1, 1'b1, 1'b1);
    push("both_time", m_word()); push("both_pm", {11'd0, m_pm});
    e = sb.pop_front(); n_cmp++;
    if (time_bus !== e.val) begin n_bad++; $display("FAIL %s: got %h expected %h", e.name, time_bus, e.val); end
    e = sb.pop_front(); n_cmp++;
    if ({11'd0, pm} !== e.val) begin n_bad++; $display("FAIL %s: got %0d expected %0d", e.name, pm, e.val); end
    set_mode = 1'b0;
    step(3);
    press(1'b1, 1'b0, 1'b0);
    press(1'b0, 1'b1, 1'b0);
    press(1'b1, 1'b1, 1'b0);
    push("run_ignore", m_word());
    e = sb.pop_front(); n_cmp++;
    if (time_bus !== e.val) begin n_bad++; $display("FAIL %s: got %h expected %h", e.name, time_bus, e.val); end
  endtask

  task automatic test_reset_mid_press();
    exp_t e;
    int   guard;
    btn_hr = 1'b1;
    guard = 0;
    while (dut.presc !== 4'd7 && guard < 3 * SEC_DIV) begin
      step(1);
      guard++;
    end
    n_cmp++;
    if (guard >= 3 * SEC_DIV) begin n_bad++; $display("FAIL presc_reach7: got %0d expected 7 within %0d cycles", dut.presc, 3 * SEC_DIV); end
    rst = 1'b1;
    push("mid_time", 12'hC00); push("mid_pm", 12'd0); push("mid_presc", 12'd0); push("mid_dp", 12'd0);
    step(1);
    e = sb.pop_front(); n_cmp++;
    if (time_bus !== e.val) begin n_bad++; $display("FAIL %s: got %h expected %h", e.name, time_bus, e.val); end
    e = sb.pop_front(); n_cmp++;
    if ({11'd0, pm} !== e.val) begin n_bad++; $display("FAIL %s: got %0d expected %0d", e.name, pm, e.val); end
    e = sb.pop_front(); n_cmp++;
    if (12'(dut.presc) !== e.val) begin n_bad++; $display("FAIL %s: got %0d expected %0d", e.name, dut.presc, e.val); end
    e = sb.pop_front(); n_cmp++;
    if ({11'd0, dp_out} !== e.val) begin n_bad++; $display("FAIL %s: got %0d expected %0d", e.name, dp_out, e.val); end
    step(1);
    rst = 1'b0;
    set_mode = 1'b1;
    m_hr = 4'd12; m_tm = 4'd0; m_mn = 4'd0; m_pm = 1'b0;
    push("held_no_step", m_word());
    step(10);
    e = sb.pop_front(); n_cmp++;
    if (time_bus !== e.val) begin n_bad++; $display("FAIL %s: got %h expected %h", e.name, time_bus, e.val); end
    btn_hr = 1'b0;
    step(3);
    set_mode = 1'b0;
    step(3);
  endtask

  task automatic test_dp_blink();
    exp_t e;
    do_reset();
    for (int k = 1; k <= SEC_DIV; k++) push($sformatf("dp_%0d", k), (k <= SEC_DIV / 2) ? 12'd1 : 12'd0);
    for (int k = 1; k <= SEC_DIV; k++) begin
      step(1);
      e = sb.pop_front(); n_cmp++;
      if ({11'd0, dp_out} !== e.val) begin n_bad++; $display("FAIL %s: got %0d expected %0d", e.name, dp_out, e.val); end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_run_carry();
    test_min_hold();
    test_both_and_run_ignore();
    test_reset_mid_press();
    test_dp_blink();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
